std_arbiter_rr: RTL and testbench
=================================

Name: std_arbiter_rr

Overview:
- Round-robin arbiter that shares one single-owner resource among REQ_COUNT requesters, e.g. a shared register-file write port or a shared bus master.
- Grants are registered and held for a whole transaction, until the owner pulses done.
- Built on the standard async-reset DFF primitive.
- Sits between requesting units and the resource's select mux; gnt drives the mux select directly.

Parameters:
- REQ_COUNT, 4, number of requesters; legal range 2..16.
- REQ_INDEX_WIDTH, 2, width of gnt_index; must equal ceil(log2(REQ_COUNT)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- areset  input  1  asynchronous active-high reset.
- req  input  REQ_COUNT  request vector; bit i is requester i; level-sensitive.
- done  input  1  owner ends its transaction; single-cycle pulse; sampled only in GRANT.
- gnt  output  REQ_COUNT  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; high exactly when gnt is non-zero.
- gnt_index  output  REQ_INDEX_WIDTH  registered binary index of the granted requester; holds its last value when idle.

Behaviour:
- Reset is asynchronous and active-high on areset; the clock is clk.
- Reset values: gnt=0, gnt_valid=0, gnt_index=0, internal priority pointer ptr=0, state=IDLE.
- Every state element uses the standard async-reset DFF behaviour: clear on posedge areset, otherwise capture on posedge clk.
- Winner selection (combinational): the first set bit of req, scanning ascending from ptr and wrapping from REQ_COUNT-1 to 0. ptr itself has highest priority.
- State IDLE:
  - If req is non-zero, the winner is registered into gnt/gnt_index, gnt_valid=1, next state GRANT. Latency is 1 cycle from req seen to gnt.
  - If req is zero, everything holds.
  - done is ignored in IDLE.
- State GRANT:
  - gnt is held stable irrespective of req; the owner dropping req does not release the grant.
  - On a cycle with done=1, ptr becomes (gnt_index+1) mod REQ_COUNT.
  - In that same done cycle, the winner is computed from the current req using the new ptr.
  - If that winner exists, it is registered as the new grant and state stays GRANT. This gives back-to-back grants with no bubble.
  - If there is no winner, gnt=0, gnt_valid=0, next state IDLE.
  - The previous owner may win again only if it is the sole requester.
- ptr changes only on done in GRANT; ptr is never advanced by an IDLE grant.
- Wrap-around: ptr+1 from REQ_COUNT-1 is 0. This holds for non-power-of-two REQ_COUNT: ptr must never hold a value >= REQ_COUNT.
- Fairness: with all requesters continuously asserting, grants rotate strictly 0,1,2,...,REQ_COUNT-1,0,...
- gnt is always one-hot or zero; a gnt with more than one bit set is a design error.
- Reset mid-transaction: gnt drops asynchronously in the same instant and ptr returns to 0. After release, arbitration restarts from IDLE on the next edge.
- Simultaneous done and a new req rising: the new req participates in that cycle's re-arbitration.
- Implementation: registers are instances of the standard async-reset DFF. Expected size is 150-250 lines.

Test Plan:
- Reset: assert areset with req=4'b1111 mid-grant -> gnt=0, gnt_valid=0, gnt_index=0 immediately; after release, next edge gives gnt=4'b0001.
- Single request: in IDLE, req=4'b0100 -> one edge later gnt=4'b0100, gnt_index=2. Drop req with done=0 -> grant held. Pulse done -> next edge gnt=0, gnt_valid=0, ptr=3.
- Rotation: req=4'b1111 held, done pulsed each grant cycle -> gnt_index sequence 0,1,2,3,0 with no idle cycle between grants.
- Priority from ptr: ptr=3 (after granting 2), req=4'b0101 -> gnt_index=0 (wraps past 3, skips nothing set). Then done -> gnt_index=2.
- Sole re-grant / done-in-IDLE: req=4'b0010 held, done each grant -> requester 1 re-granted continuously. In IDLE with req=0, pulse done -> no output change, ptr unchanged.
- REQ_COUNT=3, REQ_INDEX_WIDTH=2: req=3'b111 held with done each grant -> gnt_index 0,1,2,0; ptr never reaches 3.

Source files
------------

// File: rtl/std_arbiter_rr.sv
// Round-robin arbiter for a single-owner shared resource.
// A grant is registered and held for a whole transaction until the owner
// pulses done. On done the priority pointer moves just past the finishing
// owner and the next winner is chosen in the same cycle, so grants can
// follow each other with no idle bubble. All state lives in std_dff_ar
// instances (async active-high clear, rising-edge capture).

module std_dff_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear asynchronously on areset, otherwise capture d on the rising edge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

module std_arbiter_rr #(
    parameter int REQ_COUNT       = 4,
    parameter int REQ_INDEX_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [REQ_COUNT-1:0]       req,
    input  logic                       done,
    output logic [REQ_COUNT-1:0]       gnt,
    output logic                       gnt_valid,
    output logic [REQ_INDEX_WIDTH-1:0] gnt_index
);

    localparam int IW = REQ_INDEX_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Register outputs
    logic                 state_q_s;
    state_t               state_r;
    logic [IW-1:0]        ptr_r;
    logic [REQ_COUNT-1:0] gnt_r;
    logic                 gnt_valid_r;
    logic [IW-1:0]        gnt_index_r;

    // Next-state values
    state_t               state_nxt_s;
    logic [IW-1:0]        ptr_nxt_s;
    logic [REQ_COUNT-1:0] gnt_nxt_s;
    logic                 gnt_valid_nxt_s;
    logic [IW-1:0]        gnt_index_nxt_s;

    // Arbitration helpers
    logic                 release_s;
    logic [IW-1:0]        ptr_inc_s;
    logic [IW-1:0]        arb_ptr_s;
    logic                 found_s;
    logic [IW-1:0]        win_idx_s;
    logic [REQ_COUNT-1:0] win_onehot_s;
    logic [IW:0]          scan_idx_s;

    assign state_r = state_t'(state_q_s);

    // Pointer to use for this cycle's scan: one past the finishing owner on done, else the stored pointer.
    always_comb begin
        release_s = (state_r == ST_GRANT) && done;
        if (gnt_index_r == IW'(REQ_COUNT - 1)) begin
            ptr_inc_s = {IW{1'b0}};
        end else begin
            ptr_inc_s = gnt_index_r + IW'(1);
        end
        if (release_s) begin
            arb_ptr_s = ptr_inc_s;
        end else begin
            arb_ptr_s = ptr_r;
        end
    end

    // Find the first set request scanning upward from arb_ptr_s with wrap-around.
    always_comb begin
        found_s      = 1'b0;
        win_idx_s    = {IW{1'b0}};
        win_onehot_s = {REQ_COUNT{1'b0}};
        scan_idx_s   = {(IW+1){1'b0}};
        for (int k = 0; k < REQ_COUNT; k++) begin
            scan_idx_s = {1'b0, arb_ptr_s} + (IW+1)'(k);
            if (scan_idx_s >= (IW+1)'(REQ_COUNT)) begin
                scan_idx_s = scan_idx_s - (IW+1)'(REQ_COUNT);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!found_s && req[scan_idx_s[IW-1:0]]) begin
                found_s                              = 1'b1;
                win_idx_s                            = scan_idx_s[IW-1:0];
                win_onehot_s[scan_idx_s[IW-1:0]]     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // IDLE/GRANT transitions and the next values of the grant registers and pointer.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        gnt_nxt_s       = gnt_r;
        gnt_valid_nxt_s = gnt_valid_r;
        gnt_index_nxt_s = gnt_index_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_nxt_s       = win_onehot_s;
                    gnt_valid_nxt_s = 1'b1;
                    gnt_index_nxt_s = win_idx_s;
                    state_nxt_s     = ST_GRANT;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    ptr_nxt_s = ptr_inc_s;
                    if (found_s) begin
                        gnt_nxt_s       = win_onehot_s;
                        gnt_valid_nxt_s = 1'b1;
                        gnt_index_nxt_s = win_idx_s;
                        state_nxt_s     = ST_GRANT;
                    end else begin
                        gnt_nxt_s       = {REQ_COUNT{1'b0}};
                        gnt_valid_nxt_s = 1'b0;
                        state_nxt_s     = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                gnt_nxt_s       = {REQ_COUNT{1'b0}};
                gnt_valid_nxt_s = 1'b0;
            end
        endcase
    end

    std_dff_ar #(.W(1))         u_state_dff     (.clk(clk), .areset(areset), .d(state_nxt_s),     .q(state_q_s));
    std_dff_ar #(.W(IW))        u_ptr_dff       (.clk(clk), .areset(areset), .d(ptr_nxt_s),       .q(ptr_r));
    std_dff_ar #(.W(REQ_COUNT)) u_gnt_dff       (.clk(clk), .areset(areset), .d(gnt_nxt_s),       .q(gnt_r));
    std_dff_ar #(.W(1))         u_gnt_valid_dff (.clk(clk), .areset(areset), .d(gnt_valid_nxt_s), .q(gnt_valid_r));
    std_dff_ar #(.W(IW))        u_gnt_index_dff (.clk(clk), .areset(areset), .d(gnt_index_nxt_s), .q(gnt_index_r));

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_index = gnt_index_r;

endmodule

// File: tb/tb_std_arbiter_rr.sv
// Directed-vector bench for std_arbiter_rr: a 4-requester instance and a
// 3-requester instance sharing clock and reset.

module tb_std_arbiter_rr;

    logic       clk;
    logic       areset;
    logic [3:0] req_a;
    logic       done_a;
    logic [3:0] gnt_a;
    logic       gv_a;
    logic [1:0] gi_a;
    logic [2:0] req_b;
    logic       done_b;
    logic [2:0] gnt_b;
    logic       gv_b;
    logic [1:0] gi_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    std_arbiter_rr #(.REQ_COUNT(4), .REQ_INDEX_WIDTH(2)) dut_a (
        .clk(clk), .areset(areset), .req(req_a), .done(done_a),
        .gnt(gnt_a), .gnt_valid(gv_a), .gnt_index(gi_a)
    );

    std_arbiter_rr #(.REQ_COUNT(3), .REQ_INDEX_WIDTH(2)) dut_b (
        .clk(clk), .areset(areset), .req(req_b), .done(done_b),
        .gnt(gnt_b), .gnt_valid(gv_b), .gnt_index(gi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic v, input logic [1:0] i);
        check({tag, ".gnt"}, {28'd0, gnt_a}, {28'd0, g});
        check({tag, ".valid"}, {31'd0, gv_a}, {31'd0, v});
        check({tag, ".index"}, {30'd0, gi_a}, {30'd0, i});
    endtask

    initial begin
        areset = 1'b1;
        req_a  = 4'b0000;
        done_a = 1'b0;
        req_b  = 3'b000;
        done_b = 1'b0;
        #2;
        chk_a("reset", 4'b0000, 1'b0, 2'd0);
        tick();
        areset = 1'b0;

        // Rotation with all requesting, done every grant cycle
        req_a = 4'b1111;
        tick(); chk_a("rot0", 4'b0001, 1'b1, 2'd0);
        done_a = 1'b1;
        tick(); chk_a("rot1", 4'b0010, 1'b1, 2'd1);
        tick(); chk_a("rot2", 4'b0100, 1'b1, 2'd2);
        tick(); chk_a("rot3", 4'b1000, 1'b1, 2'd3);
        tick(); chk_a("rot4", 4'b0001, 1'b1, 2'd0);
        done_a = 1'b0; req_a = 4'b0000;
        tick(); chk_a("hold_noreq", 4'b0001, 1'b1, 2'd0);
        done_a = 1'b1;
        tick(); chk_a("to_idle", 4'b0000, 1'b0, 2'd0);   // ptr now 1
        done_a = 1'b0;

        // Single request, held after req drops, released by done
        req_a = 4'b0100;
        tick(); chk_a("single", 4'b0100, 1'b1, 2'd2);
        req_a = 4'b0000;
        tick(); chk_a("single_hold", 4'b0100, 1'b1, 2'd2);
        done_a = 1'b1;
        tick(); chk_a("single_rel", 4'b0000, 1'b0, 2'd2); // ptr now 3
        done_a = 1'b0;

        // Priority from ptr=3 wraps to 0, then done moves ptr to 1 -> 2
        req_a = 4'b0101;
        tick(); chk_a("prio_wrap", 4'b0001, 1'b1, 2'd0);
        done_a = 1'b1;
        tick(); chk_a("prio_next", 4'b0100, 1'b1, 2'd2);
        req_a = 4'b0000;
        tick(); chk_a("prio_idle", 4'b0000, 1'b0, 2'd2); // ptr now 3

        // done in IDLE is ignored; ptr remains 3
        tick(); chk_a("idle_done", 4'b0000, 1'b0, 2'd2);
        done_a = 1'b0;
        req_a = 4'b1111;
        tick(); chk_a("ptr_kept", 4'b1000, 1'b1, 2'd3);

        // Sole requester is re-granted back to back
        req_a = 4'b0010; done_a = 1'b1;
        tick(); chk_a("sole0", 4'b0010, 1'b1, 2'd1);
        tick(); chk_a("sole1", 4'b0010, 1'b1, 2'd1);
        tick(); chk_a("sole2", 4'b0010, 1'b1, 2'd1);     // ptr now 2

        // New request rising together with done takes part in re-arbitration
        req_a = 4'b1010;
        tick(); chk_a("new_req", 4'b1000, 1'b1, 2'd3);   // ptr now 2 -> 0 on next done
        done_a = 1'b0;
        req_a = 4'b1111;
        tick(); chk_a("pre_reset", 4'b1000, 1'b1, 2'd3);

        // Reset mid-grant: outputs clear immediately
        areset = 1'b1;
        #1;
        chk_a("async_rst", 4'b0000, 1'b0, 2'd0);
        tick();
        chk_a("rst_held", 4'b0000, 1'b0, 2'd0);
        areset = 1'b0;
        tick(); chk_a("post_rst", 4'b0001, 1'b1, 2'd0);
        done_a = 1'b1;
        tick(); chk_a("post_rst_next", 4'b0010, 1'b1, 2'd1);
        done_a = 1'b0; req_a = 4'b0000;

        // Three requesters: rotation wraps 2 -> 0
        req_b = 3'b111;
        tick();
        check("n3_0.gnt", {29'd0, gnt_b}, {29'd0, 3'b001});
        check("n3_0.index", {30'd0, gi_b}, {30'd0, 2'd0});
        done_b = 1'b1;
        tick();
        check("n3_1.index", {30'd0, gi_b}, {30'd0, 2'd1});
        tick();
        check("n3_2.gnt", {29'd0, gnt_b}, {29'd0, 3'b100});
        check("n3_2.index", {30'd0, gi_b}, {30'd0, 2'd2});
        tick();
        check("n3_wrap.gnt", {29'd0, gnt_b}, {29'd0, 3'b001});
        check("n3_wrap.index", {30'd0, gi_b}, {30'd0, 2'd0});
        tick();
        check("n3_again.index", {30'd0, gi_b}, {30'd0, 2'd1});
        check("n3_again.valid", {31'd0, gv_b}, {31'd0, 1'b1});
        // Only requester 2 left: pointer after granting 1 is 2, then wraps to 0
        req_b = 3'b100;
        tick();
        check("n3_sole.index", {30'd0, gi_b}, {30'd0, 2'd2});
        tick();
        check("n3_sole2.index", {30'd0, gi_b}, {30'd0, 2'd2});
        check("n3_sole2.gnt", {29'd0, gnt_b}, {29'd0, 3'b100});
        done_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
